muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  command strobe, sampled on rising clk.
REQ-005 SHALL have port funct  input  3  command: 000 MFHI, 001 MFLO, 010 MTHI, 011 MTLO, 100 MULT, 101 MULTU, 110 DIV, 111 DIVU.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (a = rs/dividend, b = rt/divisor).
REQ-007 SHALL have port result  output  WIDTH  combinational read: hi when funct=000, lo when funct=001, else 0.
REQ-008 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress; drives decode stall.
REQ-010 SHALL have port done  output  1  one-cycle pulse when hi/lo take a new mul/div result.
REQ-011 SHALL have port div_by_zero  output  1  one-cycle pulse coincident with done for a divide with b=0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX; reset state IDLE; busy = (state != IDLE).
REQ-013 In IDLE, start with funct 100-111 SHALL latch operands, clear the iteration counter, and enter RUN.
REQ-014 In IDLE, start with MTHI/MTLO SHALL write a to hi/lo at that edge; no busy, no done.
REQ-015 Start with MFHI/MFLO SHALL change no state.
REQ-016 Start while busy SHALL be ignored entirely (no operand latch, no hi/lo write).
REQ-017 RUN SHALL last exactly WIDTH cycles, one radix-2 step per cycle (shift-add multiply, restoring divide), then enter FIX.
REQ-018 FIX SHALL last one cycle, apply sign correction, write hi/lo at its closing edge, and return to IDLE.
REQ-019 done SHALL be high in the first IDLE cycle after FIX; first possible done is WIDTH+2 cycles after the accepting edge; busy high for WIDTH+1 cycles.
REQ-020 A new start SHALL be accepted in the same cycle done is high.
REQ-021 Multiply SHALL produce the full 2*WIDTH product: hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-022 Divide SHALL produce lo = quotient, hi = remainder.
REQ-023 Divide with b=0 SHALL give lo = all ones, hi = a (no sign fixup), and pulse div_by_zero.
REQ-024 Signed divide SHALL truncate toward zero, remainder takes dividend sign; most-negative / -1 SHALL give lo = most-negative, hi = 0.
REQ-025 hi/lo SHALL hold their values while busy until the FIX write.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-027 rst during RUN/FIX SHALL abort the operation with no hi/lo update and no done pulse.
REQ-028 The first start SHALL be accepted on the first rising clk after rst deasserts.

Configuration
REQ-029 Macro MULDIV_SIGNED_EN defined: MULT/DIV SHALL be two's-complement signed (magnitude operation, sign fixed in FIX).
REQ-030 Macro MULDIV_SIGNED_EN undefined: MULT/DIV SHALL behave identically to MULTU/DIVU, sign logic absent; latency unchanged.

Verification
REQ-031 WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after start edge, hi=0xFFFFFFFE, lo=0x00000001, busy high 33 cycles.
REQ-032 DIVU a=100 b=7 -> lo=14, hi=2; DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1 with done.
REQ-033 MULT a=0xFFFFFFFD b=5: with MULDIV_SIGNED_EN -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; without -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-034 With MULDIV_SIGNED_EN, DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 MTHI a=0xA5A5A5A5 then MFHI -> result=0xA5A5A5A5 next cycle; second MULTU start at cycle 5 of a busy MULTU -> ignored, first result unchanged.
REQ-036 MULTU 3*4 with rst pulsed 10 cycles in -> hi=lo=0, busy=0 immediately, no done; fresh MULTU 3*4 afterwards -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional macro MULDIV_SIGNED_EN makes MULT/DIV signed (magnitude datapath, sign applied in FIX).
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Handshake: start is a level sampled on rising clk; it is only acted on
   // while state is IDLE. done/div_by_zero are single-cycle registered pulses.

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic               is_div_q, is_div_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

`ifdef MULDIV_SIGNED_EN
   logic neg_q, neg_d;
   logic rneg_q, rneg_d;
   logic sgn_op;
`endif

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               b_zero;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         dvsr_q   <= '0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         dvsr_q   <= dvsr_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

`ifdef MULDIV_SIGNED_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         neg_q  <= neg_d;
         rneg_q <= rneg_d;
      end
   end
`endif

   // Datapath steps, evaluated every cycle and selected by the FSM.
   always_comb begin
      b_zero = (b == '0);
`ifdef MULDIV_SIGNED_EN
      sgn_op = ~funct[0];
      mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
      mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
`else
      mag_a  = a;
      mag_b  = b;
`endif
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      // Shifted partial remainder can reach 2*divisor-1, hence the extra bit.
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = {1'b0, rem_sh} - {2'b00, dvsr_q};
      div_next = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`ifdef MULDIV_SIGNED_EN
      prod_fix = neg_q  ? -acc_q : acc_q;
      quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
      prod_fix = acc_q;
      quo_fix  = acc_q[WIDTH-1:0];
      rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      dvsr_d   = dvsr_q;
      is_div_d = is_div_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_d    = neg_q;
      rneg_d   = rneg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (funct)
                  3'b010: hi_d = a;
                  3'b011: lo_d = a;
                  3'b100, 3'b101: begin
                     state_d  = S_RUN;
                     cnt_d    = '0;
                     is_div_d = 1'b0;
                     dz_d     = 1'b0;
                     acc_d    = {{WIDTH{1'b0}}, mag_b};
                     dvsr_d   = mag_a;
`ifdef MULDIV_SIGNED_EN
                     neg_d    = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_d   = 1'b0;
`endif
                  end
                  3'b110, 3'b111: begin
                     state_d  = S_RUN;
                     cnt_d    = '0;
                     is_div_d = 1'b1;
                     dz_d     = b_zero;
                     // Divide by zero runs on the raw dividend so the
                     // restoring loop leaves hi = a and lo = all ones.
                     acc_d    = {{WIDTH{1'b0}}, b_zero ? a : mag_a};
                     dvsr_d   = mag_b;
`ifdef MULDIV_SIGNED_EN
                     neg_d    = sgn_op & ~b_zero & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_d   = sgn_op & ~b_zero & a[WIDTH-1];
`endif
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            dbz_d   = dz_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (funct)
         3'b000:  result = hi_q;
         3'b001:  result = lo_q;
         default: result = '0;
      endcase
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (WIDTH=32); MULT/DIV expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_seq;

  localparam int W = 32;
  localparam logic [2:0] F_MFHI = 3'b000, F_MFLO = 3'b001, F_MTHI = 3'b010, F_MTLO = 3'b011;
  localparam logic [2:0] F_MULT = 3'b100, F_MULTU = 3'b101, F_DIV = 3'b110, F_DIVU = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   funct = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result, hi, lo;
  logic         busy, done, div_by_zero;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
    .result(result), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Caller is positioned at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int bcnt,
                        output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    start = 1'b1; funct = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; funct = F_MFHI; a = '0; b = '0;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 100);
    h = hi; l = lo; dz = div_by_zero;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/dbz got %b want 000", {busy, done, div_by_zero}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu_max();
    int lat, bcnt; logic [W-1:0] h, l; logic dz;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, h, l, dz);
    checks++; if (lat != 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", lat); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bcnt); end
    checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", h); end
    checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", l); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL multu_dbz: got %b want 0", dz); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_divu();
    int lat, bcnt; logic [W-1:0] h, l; logic dz;
    run_op(F_DIVU, 32'd100, 32'd7, lat, bcnt, h, l, dz);
    checks++; if ({h, l} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7: hi/lo got %h/%h want 00000002/0000000e", h, l); end
    checks++; if (lat != 34) begin errors++; $display("FAIL divu_latency: got %0d want 34", lat); end
    @(negedge clk);
    run_op(F_DIVU, 32'h1234_5678, 32'd0, lat, bcnt, h, l, dz);
    checks++; if ({h, l} !== {32'h1234_5678, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_by_zero: hi/lo got %h/%h want 12345678/ffffffff", h, l); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL divu_dbz_flag: got %b want 1", dz); end
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_pulse_width: got %b want 0", div_by_zero); end
  endtask

  task automatic test_signed_ops();
    int lat, bcnt; logic [W-1:0] h, l; logic dz;
    logic [W-1:0] exp_h, exp_l;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, lat, bcnt, h, l, dz);
`ifdef MULDIV_SIGNED_EN
    exp_h = 32'hFFFF_FFFF; exp_l = 32'hFFFF_FFF1;
`else
    exp_h = 32'h0000_0004; exp_l = 32'hFFFF_FFF1;
`endif
    checks++; if ({h, l} !== {exp_h, exp_l}) begin errors++; $display("FAIL mult_neg3_5: hi/lo got %h/%h want %h/%h", h, l, exp_h, exp_l); end
    checks++; if (lat != 34) begin errors++; $display("FAIL mult_latency: got %0d want 34", lat); end
    @(negedge clk);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt, h, l, dz);
`ifdef MULDIV_SIGNED_EN
    exp_h = 32'hFFFF_FFFF; exp_l = 32'hFFFF_FFFD;
`else
    exp_h = 32'h0000_0001; exp_l = 32'h7FFF_FFFC;
`endif
    checks++; if ({h, l} !== {exp_h, exp_l}) begin errors++; $display("FAIL div_neg7_2: hi/lo got %h/%h want %h/%h", h, l, exp_h, exp_l); end
    @(negedge clk);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, h, l, dz);
`ifdef MULDIV_SIGNED_EN
    exp_h = 32'h0000_0000; exp_l = 32'h8000_0000;
`else
    exp_h = 32'h8000_0000; exp_l = 32'h0000_0000;
`endif
    checks++; if ({h, l} !== {exp_h, exp_l}) begin errors++; $display("FAIL div_minneg_m1: hi/lo got %h/%h want %h/%h", h, l, exp_h, exp_l); end
    @(negedge clk);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd0, lat, bcnt, h, l, dz);
    checks++; if ({h, l, dz} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL div_neg_by_zero: hi/lo/dbz got %h/%h/%b want fffffff9/ffffffff/1", h, l, dz); end
  endtask

  task automatic test_move();
    @(negedge clk);
    start = 1'b1; funct = F_MTHI; a = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    start = 1'b0; funct = F_MFHI; a = '0;
    @(negedge clk);
    checks++; if (result !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_mfhi: result got %h want a5a5a5a5", result); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mthi_no_busy: busy/done got %b want 00", {busy, done}); end
    start = 1'b1; funct = F_MTLO; a = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    start = 1'b0; funct = F_MFLO; a = '0;
    @(negedge clk);
    checks++; if (result !== 32'h5A5A_0F0F) begin errors++; $display("FAIL mtlo_mflo: result got %h want 5a5a0f0f", result); end
    start = 1'b1; funct = F_MFHI; a = 32'h1111_1111; b = 32'h2222_2222;
    @(posedge clk); #1;
    start = 1'b0; funct = F_MULTU; a = '0; b = '0;
    @(negedge clk);
    checks++; if ({hi, lo} !== {32'hA5A5_A5A5, 32'h5A5A_0F0F}) begin errors++; $display("FAIL mfhi_no_change: hi/lo got %h/%h want a5a5a5a5/5a5a0f0f", hi, lo); end
    checks++; if ({result, busy} !== {32'h0, 1'b0}) begin errors++; $display("FAIL result_other_funct: result/busy got %h/%b want 00000000/0", result, busy); end
  endtask

  task automatic test_ignore_busy();
    int lat; int late;
    @(negedge clk);
    start = 1'b1; funct = F_MTHI; a = 32'h0000_1234;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); lat++; end
    start = 1'b1; funct = F_MULTU; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    @(negedge clk); lat++;
    funct = F_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; funct = F_MFHI; a = '0; b = '0;
    @(negedge clk); lat++;
    checks++; if ({hi, busy} !== {32'h0000_1234, 1'b1}) begin errors++; $display("FAIL hold_while_busy: hi/busy got %h/%b want 00001234/1", hi, busy); end
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (lat != 34) begin errors++; $display("FAIL ignored_start_latency: got %0d want 34", lat); end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL ignored_start_result: hi/lo got %h/%h want 00000000/0000002a", hi, lo); end
    late = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done || busy) late++; end
    checks++; if (late != 0 || lo !== 32'd42) begin errors++; $display("FAIL ignored_start_no_rerun: extra busy/done cycles %0d lo %h want 0 and 0000002a", late, lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic [W-1:0] h, l; logic dz;
    @(negedge clk);
    run_op(F_MULTU, 32'd5, 32'd5, lat, bcnt, h, l, dz);
    checks++; if ({h, l} !== {32'd0, 32'd25}) begin errors++; $display("FAIL b2b_first: hi/lo got %h/%h want 00000000/00000019", h, l); end
    run_op(F_MULTU, 32'd7, 32'd8, lat, bcnt, h, l, dz);
    checks++; if (bcnt != 33) begin errors++; $display("FAIL b2b_accept_on_done: busy cycles got %0d want 33", bcnt); end
    checks++; if ({h, l} !== {32'd0, 32'd56}) begin errors++; $display("FAIL b2b_second: hi/lo got %h/%h want 00000000/00000038", h, l); end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt, seen; logic [W-1:0] h, l; logic dz;
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({hi, lo, busy, dbg_state} !== {32'd0, 32'd0, 1'b0, 2'd0}) begin errors++; $display("FAIL abort_async_reset: hi/lo/busy/state got %h/%h/%b/%0d want 0/0/0/0", hi, lo, busy, dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done || busy || lo !== 32'd0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: activity cycles got %0d want 0", seen); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(F_MULTU, 32'd3, 32'd4, lat, bcnt, h, l, dz);
    checks++; if ({h, l} !== {32'd0, 32'd12}) begin errors++; $display("FAIL fresh_after_reset: hi/lo got %h/%h want 00000000/0000000c", h, l); end
    checks++; if (lat != 34) begin errors++; $display("FAIL first_start_after_reset: latency got %0d want 34", lat); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_divu();
    test_signed_ops();
    test_move();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
